vermimem_responder: RTL and testbench

VERMIMEM_RESPONDER -- requirements
Module: vermimem_responder

---
 rtl/vermitypes_pkg.sv | 14 +
 rtl/vermimem_array.sv | 28 ++
 rtl/vermimem_responder.sv | 128 ++++++++++++
 tb/tb_vermimem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vermitypes_pkg.sv
// Shared bus types and memory responder FSM states.
// Imported by vermimem_responder and vermimem_array.
package Vermitypes_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  wstrobe_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } vermimem_state_t;

endpackage

// File: rtl/vermimem_array.sv
// Single-port synchronous word RAM with byte-lane write enables.
// Read-before-write output register; no reset on storage or output.
module vermimem_array
  import Vermitypes_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  wstrobe_t      we,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/vermimem_responder.sv
// Valid/ready memory responder with configurable wait states.
// Define VERMIMEM_RANGE_CHECK_EN to flag and block out-of-range accesses.
module vermimem_responder
  import Vermitypes_pkg::*;
#(
  parameter int    SIZE_WORDS   = 1024,
  parameter word_t BASE_ADDRESS = '0,
  parameter int    WAIT_CYCLES  = 0
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     valid,
  output logic     ready,
  input  word_t    address,
  input  wstrobe_t wstrobe,
  input  word_t    wdata,
  output word_t    rdata,
  output logic     error
);

  localparam int AW = $clog2(SIZE_WORDS);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  vermimem_state_t state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            accept, enter_resp;

  word_t    addr_q, wdata_q;
  wstrobe_t strb_q;
  word_t    acc_addr, acc_wdata, offset, ram_q;
  wstrobe_t acc_strb;
  logic     in_range, rd_ok;
  logic     unused_bits;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx   = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CW'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Zero-wait accesses hit the RAM on the accepting edge itself
  assign acc_addr  = (state == IDLE) ? address : addr_q;
  assign acc_wdata = (state == IDLE) ? wdata   : wdata_q;
  assign acc_strb  = (state == IDLE) ? wstrobe : strb_q;
  assign offset    = acc_addr - BASE_ADDRESS;

`ifdef VERMIMEM_RANGE_CHECK_EN
  assign in_range = offset < (word_t'(SIZE_WORDS) << 2);
`else
  assign in_range = 1'b1;
`endif

  assign unused_bits = ^{offset[31:AW+2], offset[1:0]};

  vermimem_array #(
    .DEPTH (SIZE_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (enter_resp),
    .we    (acc_strb & {4{in_range}}),
    .addr  (offset[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rd_ok   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_q  <= address;
        wdata_q <= wdata;
        strb_q  <= wstrobe;
      end
      if (enter_resp) rd_ok <= in_range;
    end
  end

`ifdef VERMIMEM_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= enter_resp & ~in_range;
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  // RAM output has no reset; gate it so reset and errors read as zero
  assign rdata = rd_ok ? ram_q : '0;
  assign ready = (state == RESP);

endmodule

// File: tb/tb_vermimem_responder.sv
// Randomized bench for vermimem_responder against a word-array model.
// Two instances: zero-wait at base 0, three-wait at base 0x100.
module tb_vermimem_responder;
  import Vermitypes_pkg::*;

  localparam int SW = 16;

  logic     clk = 1'b0;
  logic     reset_n = 1'b0;
  logic     vld [2];
  logic     rdy [2];
  logic     err [2];
  word_t    adr [2];
  word_t    wdt [2];
  word_t    rdt [2];
  wstrobe_t stb [2];

  word_t model [2][SW];
  bit    known [2][SW];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  vermimem_responder #(
    .SIZE_WORDS   (SW),
    .BASE_ADDRESS (32'h0),
    .WAIT_CYCLES  (0)
  ) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (vld[0]),
    .ready   (rdy[0]),
    .address (adr[0]),
    .wstrobe (stb[0]),
    .wdata   (wdt[0]),
    .rdata   (rdt[0]),
    .error   (err[0])
  );

  vermimem_responder #(
    .SIZE_WORDS   (SW),
    .BASE_ADDRESS (32'h100),
    .WAIT_CYCLES  (3)
  ) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (vld[1]),
    .ready   (rdy[1]),
    .address (adr[1]),
    .wstrobe (stb[1]),
    .wdata   (wdt[1]),
    .rdata   (rdt[1]),
    .error   (err[1])
  );

  function automatic word_t base_of(input int k);
    return (k == 1) ? 32'h100 : 32'h0;
  endfunction

  function automatic int wait_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  task automatic chk(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input int k, input word_t a, input wstrobe_t s,
                        input word_t d, input bit drop, input bit scram);
    word_t diff, nw, e_rd;
    int    idx, n;
    bit    inr, e_err, e_known, got;
    diff = a - base_of(k);
    idx  = int'((diff / 4) % SW);
    inr  = (a >= base_of(k)) && (a < base_of(k) + 4 * SW);
`ifdef VERMIMEM_RANGE_CHECK_EN
    e_err = !inr;
`else
    e_err = 1'b0;
`endif
    e_rd    = e_err ? 32'h0 : model[k][idx];
    e_known = e_err || known[k][idx];
    if (!e_err && s != 4'h0) begin
      nw = model[k][idx];
      for (int b = 0; b < 4; b++)
        if (s[b]) nw[8*b +: 8] = d[8*b +: 8];
      model[k][idx] = nw;
      known[k][idx] = known[k][idx] || (s == 4'hF);
    end
    vld[k] = 1'b1;
    adr[k] = a;
    stb[k] = s;
    wdt[k] = d;
    n   = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (rdy[k]) got = 1'b1;
      else if (n == 1) begin
        if (drop) vld[k] = 1'b0;
        if (scram) begin
          adr[k] = $urandom;
          wdt[k] = $urandom;
          stb[k] = wstrobe_t'($urandom_range(0, 15));
        end
      end
    end
    vld[k] = 1'b0;
    if (!got) begin
      chk("timeout", 32'h0, 32'h1);
      return;
    end
    chk("latency", word_t'(n), word_t'(1 + wait_of(k)));
    chk("error", word_t'(err[k]), word_t'(e_err));
    if (e_known) chk("rdata", rdt[k], e_rd);
    @(posedge clk);
    #1;
    chk("ready_pulse", word_t'(rdy[k]), 32'h0);
    if (e_known) chk("rdata_hold", rdt[k], e_rd);
  endtask

  task automatic b2b(input int k, input int edges,
                     input int first, input int gap);
    int t1, t2;
    t1 = -1;
    t2 = -1;
    vld[k] = 1'b1;
    adr[k] = base_of(k);
    stb[k] = 4'h0;
    for (int i = 1; i <= edges; i++) begin
      @(posedge clk);
      #1;
      if (rdy[k]) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
    end
    vld[k] = 1'b0;
    chk("b2b_first", word_t'(t1), word_t'(first));
    chk("b2b_gap", word_t'(t2 - t1), word_t'(gap));
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0;
      adr[k] = '0;
      stb[k] = '0;
      wdt[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", word_t'(rdy[k]), 32'h0);
      chk("rst_error", word_t'(err[k]), 32'h0);
      chk("rst_rdata", rdt[k], 32'h0);
    end
    reset_n = 1'b1;

    do_txn(0, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0);
    do_txn(0, 32'h10, 4'h0, 32'h0, 0, 0);
    chk("rd_deadbeef", rdt[0], 32'hDEADBEEF);

    do_txn(0, 32'h10, 4'hF, 32'h11223344, 0, 0);
    do_txn(0, 32'h13, 4'h8, 32'hAAAAAAAA, 0, 0);
    do_txn(0, 32'h10, 4'h0, 32'h0, 0, 0);
    chk("byte_write", rdt[0], 32'hAA223344);

    do_txn(0, 32'h00, 4'hF, 32'h00001234, 0, 0);
    do_txn(0, 32'h02, 4'hC, 32'hBEEFBEEF, 0, 0);
    chk("half_prewrite", rdt[0], 32'h00001234);
    do_txn(0, 32'h00, 4'h0, 32'h0, 0, 0);
    chk("half_write", rdt[0], 32'hBEEF1234);

    do_txn(0, 32'h40, 4'hF, 32'hCAFEF00D, 0, 0);
`ifdef VERMIMEM_RANGE_CHECK_EN
    chk("oor_error", word_t'(err[0]), 32'h0);
    chk("oor_rdata", rdt[0], 32'h0);
`else
    chk("wrap_rdata", rdt[0], 32'hBEEF1234);
`endif
    do_txn(0, 32'h00, 4'h0, 32'h0, 0, 0);
`ifdef VERMIMEM_RANGE_CHECK_EN
    chk("oor_word0", rdt[0], 32'hBEEF1234);
`else
    chk("wrap_word0", rdt[0], 32'hCAFEF00D);
`endif

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < SW; i++)
        do_txn(k, base_of(k) + word_t'(4 * i), 4'hF,
               $urandom | 32'h1, 0, 0);

    do_txn(1, 32'h104, 4'h0, 32'h0, 0, 0);
    b2b(1, 10, 4, 5);
    b2b(0, 6, 1, 2);

    do_txn(1, 32'h108, 4'h0, 32'h0, 0, 0);
    vld[1] = 1'b1;
    adr[1] = 32'h108;
    stb[1] = 4'hF;
    wdt[1] = 32'h55555555;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    vld[1]  = 1'b0;
    #1;
    chk("abort_ready", word_t'(rdy[1]), 32'h0);
    chk("abort_error", word_t'(err[1]), 32'h0);
    chk("abort_rdata", rdt[1], 32'h0);
    chk("abort_rdata0", rdt[0], 32'h0);
    #2;
    reset_n = 1'b1;
    do_txn(0, 32'h04, 4'h0, 32'h0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_ready", word_t'(rdy[1]), 32'h0);
    end
    do_txn(1, 32'h108, 4'h0, 32'h0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 2; k++) begin
        word_t    a;
        wstrobe_t s;
        a = base_of(k) - 32'd32 + word_t'($urandom_range(0, 127));
        s = ($urandom_range(0, 1) == 1) ? 4'h0
                                         : wstrobe_t'($urandom_range(0, 15));
        do_txn(k, a, s, $urandom, bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
